timer_entry_loader: RTL and testbench

//  Front end of the microwave timer: collects keypad BCD digits into an MM:SS entry register,

---
 rtl/timer_entry_loader_pkg.sv | 36 +++
 rtl/timer_entry_loader_if.sv | 35 +++
 rtl/timer_entry_loader_shifter.sv | 59 +++++
 rtl/timer_entry_loader.sv | 144 ++++++++++++++
 tb/tb_timer_entry_loader.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/timer_entry_loader_pkg.sv
// Shared types, widths and helpers for the microwave timer entry/loader front end.
package timer_entry_loader_pkg;

  localparam int unsigned DIGIT_W      = 4;
  localparam int unsigned CNT_W        = 3;
  localparam int unsigned BCD_MAX      = 9;
  localparam int unsigned SEC_TENS_MAX = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_PAUSE,
    ST_DONE
  } state_t;

  // MM:SS entry payload, most significant digit first
  typedef struct packed {
    logic [DIGIT_W-1:0] min_tens;
    logic [DIGIT_W-1:0] min_ones;
    logic [DIGIT_W-1:0] sec_tens;
    logic [DIGIT_W-1:0] sec_ones;
  } entry_t;

  // Seconds above 59 collapse to 59 so the mod6 tens counter is never loaded out of range
  function automatic entry_t normalise(input entry_t e);
    entry_t r;
    r = e;
    if (e.sec_tens > DIGIT_W'(SEC_TENS_MAX)) begin
      r.sec_tens = DIGIT_W'(SEC_TENS_MAX);
      r.sec_ones = DIGIT_W'(BCD_MAX);
    end
    return r;
  endfunction

endpackage

// File: rtl/timer_entry_loader_if.sv
// Keypad/control inputs and counter-chain load/control outputs of the timer front end.
interface timer_entry_loader_if;
  import timer_entry_loader_pkg::*;

  logic               key_valid;
  logic [DIGIT_W-1:0] key_digit;
  logic               start;
  logic               stop_clear;
  logic               zero_in;

  logic [DIGIT_W-1:0] sec_ones;
  logic [DIGIT_W-1:0] sec_tens;
  logic [DIGIT_W-1:0] min_ones;
  logic [DIGIT_W-1:0] min_tens;
  logic               loadn;
  logic               enable;
  logic               cnt_clearn;
  logic               done;
  logic [CNT_W-1:0]   digit_count;

  // Keypad / counter-chain side
  modport master (
    output key_valid, key_digit, start, stop_clear, zero_in,
    input  sec_ones, sec_tens, min_ones, min_tens,
    input  loadn, enable, cnt_clearn, done, digit_count
  );

  // Timer front end side
  modport slave (
    input  key_valid, key_digit, start, stop_clear, zero_in,
    output sec_ones, sec_tens, min_ones, min_tens,
    output loadn, enable, cnt_clearn, done, digit_count
  );

endinterface

// File: rtl/timer_entry_loader_shifter.sv
// BCD entry register: shifts keypad digits in from the right, counts them, clears and
// normalises on request; the visible copy always carries normalised seconds.
module bcd_entry_shifter
  import timer_entry_loader_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4
) (
  input  logic               clock,
  input  logic               clearn,
  input  logic               shift_c,
  input  logic [DIGIT_W-1:0] digit,
  input  logic               clear_c,
  input  logic               normalise_c,
  output entry_t             entry,
  output logic [CNT_W-1:0]   digit_count,
  output logic               entry_zero_c
);

  entry_t           raw_q, raw_d;
  entry_t           view_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             accept_c;

  assign accept_c = shift_c
                    && (digit <= DIGIT_W'(BCD_MAX))
                    && (count_q < CNT_W'(NUM_DIGITS));

  // Clear beats normalise beats shift
  always_comb begin
    raw_d   = raw_q;
    count_d = count_q;
    if (clear_c) begin
      raw_d   = '0;
      count_d = '0;
    end else if (normalise_c) begin
      raw_d = normalise(raw_q);
    end else if (accept_c) begin
      raw_d   = entry_t'({raw_q.min_ones, raw_q.sec_tens, raw_q.sec_ones, digit});
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge clearn) begin
    if (!clearn) begin
      raw_q   <= '0;
      view_q  <= '0;
      count_q <= '0;
    end else begin
      raw_q   <= raw_d;
      view_q  <= normalise(raw_d);
      count_q <= count_d;
    end
  end

  assign entry        = view_q;
  assign digit_count  = count_q;
  assign entry_zero_c = (raw_q == '0);

endmodule

// File: rtl/timer_entry_loader.sv
// Timer front end: entry -> load -> run -> pause/done sequencing and registered
// load/enable/clear control of the mod10/mod6 down-counter chain.
module timer_entry_loader
  import timer_entry_loader_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned DONE_CYCLES = 8
) (
  input  logic                 clock,
  input  logic                 clearn,
  timer_entry_loader_if.slave  bus
);

  localparam int unsigned HOLD_W = (DONE_CYCLES > 1) ? $clog2(DONE_CYCLES) : 1;

  state_t            state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              loadn_q, loadn_d;
  logic              enable_q, enable_d;
  logic              cnt_clearn_q, cnt_clearn_d;
  logic              done_q, done_d;

  logic              shift_c;
  logic              clear_c;
  logic              normalise_c;
  logic              entry_zero_c;
  entry_t            entry;
  logic [CNT_W-1:0]  digit_count;

  bcd_entry_shifter #(
    .NUM_DIGITS (NUM_DIGITS)
  ) u_shifter (
    .clock        (clock),
    .clearn       (clearn),
    .shift_c      (shift_c),
    .digit        (bus.key_digit),
    .clear_c      (clear_c),
    .normalise_c  (normalise_c),
    .entry        (entry),
    .digit_count  (digit_count),
    .entry_zero_c (entry_zero_c)
  );

  always_ff @(posedge clock or negedge clearn) begin
    if (!clearn) begin
      state_q      <= ST_IDLE;
      hold_q       <= '0;
      loadn_q      <= 1'b1;
      enable_q     <= 1'b0;
      cnt_clearn_q <= 1'b1;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      loadn_q      <= loadn_d;
      enable_q     <= enable_d;
      cnt_clearn_q <= cnt_clearn_d;
      done_q       <= done_d;
    end
  end

  // Next state and next registered control values; priority stop_clear > start > key
  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    loadn_d      = 1'b1;
    enable_d     = 1'b0;
    cnt_clearn_d = 1'b1;
    done_d       = 1'b0;
    shift_c      = 1'b0;
    clear_c      = 1'b0;
    normalise_c  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.stop_clear) begin
          clear_c      = 1'b1;
          cnt_clearn_d = 1'b0;
        end else if (bus.start) begin
          if (!entry_zero_c) begin
            state_d     = ST_LOAD;
            normalise_c = 1'b1;
            loadn_d     = 1'b0;
          end
        end else if (bus.key_valid) begin
          shift_c = 1'b1;
        end
      end

      ST_LOAD: begin
        state_d  = ST_RUN;
        enable_d = 1'b1;
      end

      ST_RUN: begin
        if (bus.zero_in) begin
          state_d = ST_DONE;
          hold_d  = '0;
          done_d  = 1'b1;
        end else if (bus.stop_clear) begin
          state_d = ST_PAUSE;
        end else begin
          enable_d = 1'b1;
        end
      end

      ST_PAUSE: begin
        if (bus.stop_clear) begin
          state_d      = ST_IDLE;
          clear_c      = 1'b1;
          cnt_clearn_d = 1'b0;
        end else if (bus.start) begin
          state_d  = ST_RUN;
          enable_d = 1'b1;
        end
      end

      ST_DONE: begin
        if (bus.stop_clear || (hold_q == HOLD_W'(DONE_CYCLES - 1))) begin
          state_d = ST_IDLE;
          clear_c = 1'b1;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
          done_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.sec_ones    = entry.sec_ones;
  assign bus.sec_tens    = entry.sec_tens;
  assign bus.min_ones    = entry.min_ones;
  assign bus.min_tens    = entry.min_tens;
  assign bus.digit_count = digit_count;
  assign bus.loadn       = loadn_q;
  assign bus.enable      = enable_q;
  assign bus.cnt_clearn  = cnt_clearn_q;
  assign bus.done        = done_q;

endmodule

// File: tb/tb_timer_entry_loader.sv
// Directed per-cycle vector bench for timer_entry_loader plus an async reset sequence.
module tb_timer_entry_loader;

  logic clock;
  logic clearn;

  timer_entry_loader_if bus ();

  timer_entry_loader #(
    .NUM_DIGITS  (4),
    .DONE_CYCLES (8)
  ) dut (
    .clock  (clock),
    .clearn (clearn),
    .bus    (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // expected: {min_tens,min_ones,sec_tens,sec_ones, digit_count, loadn, enable, cnt_clearn, done}
  typedef struct {
    logic        kv;
    logic [3:0]  kd;
    logic        st;
    logic        sc;
    logic        z;
    logic [22:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  localparam logic [22:0] RESET_VAL = {16'h0000, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0};

  function void add(input logic kv, input logic [3:0] kd, input logic st, input logic sc,
                    input logic z, input logic [15:0] ent, input logic [2:0] cnt,
                    input logic ld, input logic en, input logic clr, input logic dn);
    vec_t v;
    v.kv  = kv;
    v.kd  = kd;
    v.st  = st;
    v.sc  = sc;
    v.z   = z;
    v.exp = {ent, cnt, ld, en, clr, dn};
    vecs.push_back(v);
  endfunction

  function logic [22:0] snap();
    return {bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones,
            bus.digit_count, bus.loadn, bus.enable, bus.cnt_clearn, bus.done};
  endfunction

  task automatic check(input string name, input logic [22:0] got, input logic [22:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_invariant(input string name);
    logic ok;
    ok = !(!bus.loadn && !bus.cnt_clearn) && !(bus.enable && (!bus.loadn || !bus.cnt_clearn));
    check(name, 23'(ok), 23'(1'b1));
  endtask

  task automatic drive(input logic kv, input logic [3:0] kd, input logic st,
                       input logic sc, input logic z);
    bus.key_valid  = kv;
    bus.key_digit  = kd;
    bus.start      = st;
    bus.stop_clear = sc;
    bus.zero_in    = z;
  endtask

  initial begin
    // entry 1,3,0 -> 01:30, load, run, pause/resume, cancel
    add(1,4'd1,0,0,0, 16'h0001,3'd1, 1,0,1,0);
    add(1,4'd3,0,0,0, 16'h0013,3'd2, 1,0,1,0);
    add(1,4'd0,0,0,0, 16'h0130,3'd3, 1,0,1,0);
    add(0,4'd0,1,0,0, 16'h0130,3'd3, 0,0,1,0);
    add(0,4'd0,0,0,0, 16'h0130,3'd3, 1,1,1,0);
    add(0,4'd0,0,0,0, 16'h0130,3'd3, 1,1,1,0);
    add(0,4'd0,0,1,0, 16'h0130,3'd3, 1,0,1,0);
    add(1,4'd5,0,0,0, 16'h0130,3'd3, 1,0,1,0);
    add(0,4'd0,1,0,0, 16'h0130,3'd3, 1,1,1,0);
    add(0,4'd0,0,1,0, 16'h0130,3'd3, 1,0,1,0);
    add(0,4'd0,0,1,0, 16'h0000,3'd0, 1,0,0,0);
    add(0,4'd0,0,0,0, 16'h0000,3'd0, 1,0,1,0);
    // keys 9,9 -> 00:59, load, zero_in beats stop_clear, done held 8 cycles
    add(1,4'd9,0,0,0, 16'h0009,3'd1, 1,0,1,0);
    add(1,4'd9,0,0,0, 16'h0059,3'd2, 1,0,1,0);
    add(0,4'd0,1,0,0, 16'h0059,3'd2, 0,0,1,0);
    add(0,4'd0,0,0,0, 16'h0059,3'd2, 1,1,1,0);
    add(0,4'd0,0,1,1, 16'h0059,3'd2, 1,0,1,1);
    for (int i = 0; i < 7; i++) add(0,4'd0,0,0,0, 16'h0059,3'd2, 1,0,1,1);
    add(0,4'd0,0,0,0, 16'h0000,3'd0, 1,0,1,0);
    // five keys, fifth ignored; bad digit; zero-entry start; priorities
    add(1,4'd1,0,0,0, 16'h0001,3'd1, 1,0,1,0);
    add(1,4'd2,0,0,0, 16'h0012,3'd2, 1,0,1,0);
    add(1,4'd3,0,0,0, 16'h0123,3'd3, 1,0,1,0);
    add(1,4'd4,0,0,0, 16'h1234,3'd4, 1,0,1,0);
    add(1,4'd5,0,0,0, 16'h1234,3'd4, 1,0,1,0);
    add(0,4'd0,0,1,0, 16'h0000,3'd0, 1,0,0,0);
    add(1,4'd12,0,0,0,16'h0000,3'd0, 1,0,1,0);
    add(0,4'd0,1,0,0, 16'h0000,3'd0, 1,0,1,0);
    add(1,4'd7,1,0,0, 16'h0000,3'd0, 1,0,1,0);
    add(1,4'd7,0,0,0, 16'h0007,3'd1, 1,0,1,0);
    add(0,4'd0,1,1,0, 16'h0000,3'd0, 1,0,0,0);
    add(1,4'd2,0,0,0, 16'h0002,3'd1, 1,0,1,0);
    add(0,4'd0,1,0,0, 16'h0002,3'd1, 0,0,1,0);
    add(0,4'd0,1,1,0, 16'h0002,3'd1, 1,1,1,0);
    add(0,4'd0,0,1,0, 16'h0002,3'd1, 1,0,1,0);
    add(0,4'd0,1,1,0, 16'h0000,3'd0, 1,0,0,0);
    // zero_in in first RUN cycle, early exit from DONE
    add(1,4'd4,0,0,0, 16'h0004,3'd1, 1,0,1,0);
    add(0,4'd0,1,0,0, 16'h0004,3'd1, 0,0,1,0);
    add(0,4'd0,0,0,0, 16'h0004,3'd1, 1,1,1,0);
    add(0,4'd0,0,0,1, 16'h0004,3'd1, 1,0,1,1);
    add(0,4'd0,0,1,0, 16'h0000,3'd0, 1,0,1,0);

    drive(0, 4'd0, 0, 0, 0);
    clearn = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("reset_state", snap(), RESET_VAL);
    clearn = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].kv, vecs[i].kd, vecs[i].st, vecs[i].sc, vecs[i].z);
      @(posedge clock);
      #1;
      check($sformatf("vec%0d", i), snap(), vecs[i].exp);
      check_invariant($sformatf("vec%0d_ctl_excl", i));
    end

    // Async reset in the middle of RUN
    drive(1, 4'd6, 0, 0, 0);
    @(posedge clock); #1;
    drive(0, 4'd0, 1, 0, 0);
    @(posedge clock); #1;
    check("rst_seq_load", snap(), {16'h0006, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0});
    drive(0, 4'd0, 0, 0, 0);
    @(posedge clock); #1;
    check("rst_seq_run", snap(), {16'h0006, 3'd1, 1'b1, 1'b1, 1'b1, 1'b0});
    #3;
    clearn = 1'b0;
    #1;
    check("rst_mid_run", snap(), RESET_VAL);
    @(negedge clock);
    clearn = 1'b1;
    @(posedge clock); #1;
    check("rst_release_idle", snap(), RESET_VAL);
    drive(0, 4'd0, 1, 0, 0);
    @(posedge clock); #1;
    check("rst_start_zero_ignored", snap(), RESET_VAL);
    drive(0, 4'd0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
